inst_mem_loader: RTL and testbench



---
 rtl/inst_mem_loader.sv | 172 +++++++++++++++++
 tb/tb_inst_mem_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Boot loader: parses a COUNT / data / CSUM byte stream into 16-bit instruction-memory writes
// and keeps the core in reset until a checksum-valid image has been loaded.
module inst_mem_loader #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned MAX_WORDS = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CW = ADDR_W + 1;
  localparam logic [7:0] MaxWordsB = 8'(MAX_WORDS);

  typedef enum logic [2:0] {StIdle, StCount, StHi, StLo, StCsum} state_e;

  state_e state_q, state_d;

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CW-1:0]     words_q, words_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     count_q, count_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        csum_q, csum_d;

  logic          xfer;
  logic          count_bad;
  logic [CW-1:0] idx_inc;

  assign rx_ready  = (state_q != StIdle);
  assign busy      = (state_q != StIdle);
  assign xfer      = rx_valid & rx_ready;
  assign count_bad = (rx_data == 8'h00) || (rx_data > MaxWordsB);
  assign idx_inc   = idx_q + CW'(1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StCount;
      StCount: if (xfer) state_d = count_bad ? StIdle : StHi;
      StHi:    if (xfer) state_d = StLo;
      StLo:    if (xfer) state_d = (idx_inc < count_q) ? StHi : StCsum;
      StCsum:  if (xfer) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next-state logic; write strobe and done are single-cycle pulses
  always_comb begin
    wr_en_d    = 1'b0;
    done_d     = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    cpu_hold_d = cpu_hold_q;
    err_d      = err_q;
    words_d    = words_q;
    idx_d      = idx_q;
    count_d    = count_q;
    hi_d       = hi_q;
    csum_d     = csum_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cpu_hold_d = 1'b1;
          err_d      = 1'b0;
          words_d    = '0;
          idx_d      = '0;
          csum_d     = 8'h00;
        end
      end
      StCount: begin
        if (xfer) begin
          if (count_bad) begin
            err_d = 1'b1;
          end else begin
            count_d = rx_data[CW-1:0];
          end
        end
      end
      StHi: begin
        if (xfer) begin
          hi_d   = rx_data;
          csum_d = csum_q + rx_data;
        end
      end
      StLo: begin
        if (xfer) begin
          csum_d    = csum_q + rx_data;
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q[ADDR_W-1:0];
          wr_data_d = {hi_q, rx_data};
          idx_d     = idx_inc;
          words_d   = idx_inc;
        end
      end
      StCsum: begin
        if (xfer) begin
          if (rx_data == csum_q) begin
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 16'h0000;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      words_q    <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      hi_q       <= 8'h00;
      csum_q     <= 8'h00;
    end else begin
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      words_q    <= words_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      hi_q       <= hi_d;
      csum_q     <= csum_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: expected writes are queued as frames are driven and
// checked by a monitor whenever the write strobe fires.
module tb_inst_mem_loader;

  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [19:0] exp_q[$];
  logic [15:0] img[15];

  inst_mem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(15)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Write monitor / scoreboard
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (wr_en) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, none expected", wr_addr, wr_data);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          fails++;
          $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   wr_addr, wr_data, e[19:16], e[15:0]);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge following the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      tests++;
      fails++;
      $display("FAIL rx_ready_timeout: rx_ready=%b after %0d cycles, required 1", rx_ready, n);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'hxx;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_frame(input int n, input int gap, input bit corrupt, input bit mid_start);
    logic [7:0] cs;
    cs = 8'h00;
    send_byte(8'(n), gap);
    for (int i = 0; i < n; i++) begin
      send_byte(img[i][15:8], gap);
      cs = cs + img[i][15:8];
      if (mid_start && i == 0) pulse_start();
      exp_q.push_back({4'(i), img[i]});
      send_byte(img[i][7:0], gap);
      cs = cs + img[i][7:0];
    end
    send_byte(corrupt ? cs + 8'h01 : cs, gap);
  endtask

  task automatic check_queue_empty(input string name);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_pending_writes: %0d outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_end(input string name, input int dn0, input int exp_done,
                           input logic exp_err, input logic exp_hold, input int exp_words);
    tests++;
    if (done_cnt - dn0 !== exp_done || err !== exp_err || cpu_hold !== exp_hold ||
        busy !== 1'b0 || rx_ready !== 1'b0 || int'(words_loaded) !== exp_words) begin
      fails++;
      $display("FAIL %s_end: done_pulses=%0d err=%b hold=%b busy=%b rdy=%b words=%0d, required %0d %b %b 0 0 %0d",
               name, done_cnt - dn0, err, cpu_hold, busy, rx_ready, words_loaded,
               exp_done, exp_err, exp_hold, exp_words);
    end
    check_queue_empty(name);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tests++;
    if (cpu_hold !== 1'b1 || rx_ready !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0 ||
        err !== 1'b0 || words_loaded !== 5'd0 || busy !== 1'b0 || wr_addr !== 4'd0) begin
      fails++;
      $display("FAIL reset: hold=%b rdy=%b wr_en=%b done=%b err=%b words=%0d busy=%b",
               cpu_hold, rx_ready, wr_en, done, err, words_loaded, busy);
    end
  endtask

  task automatic test_good_load();
    int dn0;
    dn0 = done_cnt;
    pulse_start();
    tests++;
    if (busy !== 1'b1 || rx_ready !== 1'b1) begin
      fails++;
      $display("FAIL good_busy: busy=%b rdy=%b, required 1 1", busy, rx_ready);
    end
    send_byte(8'h02, 0);
    send_byte(8'h50, 0);
    exp_q.push_back({4'd0, 16'h5000});
    send_byte(8'h00, 0);
    tests++;
    if (wr_en !== 1'b1 || wr_addr !== 4'd0 || wr_data !== 16'h5000) begin
      fails++;
      $display("FAIL good_first_write_latency: wr_en=%b addr=%0d data=%h, required 1 0 5000",
               wr_en, wr_addr, wr_data);
    end
    send_byte(8'h11, 0);
    exp_q.push_back({4'd1, 16'h1111});
    send_byte(8'h11, 0);
    send_byte(8'h72, 0);
    tests++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || words_loaded !== 5'd2 || err !== 1'b0) begin
      fails++;
      $display("FAIL good_done: done=%b hold=%b words=%0d err=%b, required 1 0 2 0",
               done, cpu_hold, words_loaded, err);
    end
    @(negedge clk);
    check_end("good", dn0, 1, 1'b0, 1'b0, 2);
  endtask

  task automatic test_bad_csum();
    int dn0;
    dn0 = done_cnt;
    img[0] = 16'h5000;
    img[1] = 16'h1111;
    pulse_start();
    tests++;
    if (cpu_hold !== 1'b1) begin
      fails++;
      $display("FAIL bad_csum_hold_on_start: hold=%b, required 1", cpu_hold);
    end
    send_frame(2, 0, 1'b1, 1'b0);
    @(negedge clk);
    check_end("bad_csum", dn0, 0, 1'b1, 1'b1, 2);
  endtask

  task automatic test_illegal_count();
    logic [7:0] counts[2];
    counts[0] = 8'h00;
    counts[1] = 8'h10;
    for (int k = 0; k < 2; k++) begin
      int dn0;
      dn0 = done_cnt;
      pulse_start();
      send_byte(counts[k], 0);
      // A following data byte must not be consumed once idle.
      rx_valid = 1'b1;
      rx_data  = 8'hAA;
      repeat (3) @(negedge clk);
      rx_valid = 1'b0;
      check_end(k == 0 ? "count_zero" : "count_16", dn0, 0, 1'b1, 1'b1, 0);
    end
  endtask

  task automatic test_backpressure();
    int dn0;
    dn0 = done_cnt;
    img[0] = 16'h5000;
    img[1] = 16'h1111;
    pulse_start();
    send_frame(2, 3, 1'b0, 1'b1);
    check_end("backpressure", dn0, 1, 1'b0, 1'b0, 2);
  endtask

  task automatic test_max_words();
    int dn0;
    dn0 = done_cnt;
    for (int i = 0; i < 15; i++) img[i] = 16'($urandom);
    pulse_start();
    send_frame(15, 0, 1'b0, 1'b0);
    @(negedge clk);
    check_end("max_words", dn0, 1, 1'b0, 1'b0, 15);
  endtask

  task automatic test_reset_mid_frame();
    int dn0;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'hAB, 0);
    exp_q.push_back({4'd0, 16'hABCD});
    send_byte(8'hCD, 0);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    tests++;
    if (busy !== 1'b0 || cpu_hold !== 1'b1 || words_loaded !== 5'd0 || rx_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_frame: busy=%b hold=%b words=%0d rdy=%b, required 0 1 0 0",
               busy, cpu_hold, words_loaded, rx_ready);
    end
    check_queue_empty("reset_mid_frame");
    dn0 = done_cnt;
    img[0] = 16'h1234;
    img[1] = 16'hFEDC;
    pulse_start();
    send_frame(2, 1, 1'b0, 1'b0);
    check_end("after_reset", dn0, 1, 1'b0, 1'b0, 2);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_load();
    test_bad_csum();
    test_illegal_count();
    test_backpressure();
    test_max_words();
    test_reset_mid_frame();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
